// File: rtl/output_stream_tx_pkg.sv
`default_nettype none
// ============================================================================
// output_stream_tx_pkg : sizing helpers and output-matrix framing function
// Revision: 1.0
// ============================================================================
package output_stream_tx_pkg;

  function automatic int k_bits(input int maxk);
    return $clog2(maxk + 1);
  endfunction

  function automatic int cnt_bits(input int rows, input int cols);
    return $clog2(rows * cols);
  endfunction

  // Index of the final word of a valid-convolution output matrix.
  function automatic int out_matrix_last(input int rows, input int cols, input int k);
    return (rows - k + 1) * (cols - k + 1) - 1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/output_stream_tx_memory_2p.sv
`default_nettype none
// ============================================================================
// memory_2p : simple dual-port RAM, one write port, one registered read port
// Revision: 1.0
// ============================================================================
module memory_2p #(
  parameter int WIDTH = 48,
  parameter int SIZE  = 8,
  localparam int AW   = $clog2(SIZE)
) (
  input  logic             clk,
  input  logic             wr_en,
  input  logic [AW-1:0]    wr_addr,
  input  logic [WIDTH-1:0] data_in,
  input  logic [AW-1:0]    rd_addr,
  output logic [WIDTH-1:0] data_out
);

  logic [WIDTH-1:0] mem [SIZE];

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= data_in;
    data_out <= mem[rd_addr];
  end

endmodule
`default_nettype wire

// File: rtl/output_stream_tx.sv
`default_nettype none
// ============================================================================
// output_stream_tx : FIFO-buffered AXI-Stream transmitter with matrix TLAST
// Revision: 1.0
// ============================================================================
module output_stream_tx
  import output_stream_tx_pkg::*;
#(
  parameter int OUTW   = 48,
  parameter int DEPTH  = 8,
  parameter int R      = 9,
  parameter int C      = 8,
  parameter int MAXK   = 4,
  localparam int K_BITS = k_bits(MAXK)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [OUTW-1:0]   in_data,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [K_BITS-1:0] K,
  output logic [OUTW-1:0]   AXIS_TDATA,
  output logic              AXIS_TVALID,
  input  logic              AXIS_TREADY,
  output logic              AXIS_TLAST,
  output logic              matrix_sent
);

  localparam int CNT_BITS = cnt_bits(R, C);
  localparam int AW       = $clog2(DEPTH);
  localparam int FW       = $clog2(DEPTH + 1);
  localparam logic [FW-1:0] C_DEPTH = FW'(DEPTH);

  logic [AW-1:0]       r_wr_ptr, r_rd_ptr;
  logic [FW-1:0]       r_count, w_count_nxt;
  logic                r_in_ready;
  logic                r_rd_pend;
  logic [1:0]          r_sk_cnt;
  logic [OUTW-1:0]     r_sk0, r_sk1;
  logic [CNT_BITS-1:0] r_out_cnt;
  logic                r_matrix_sent;
  logic [OUTW-1:0]     w_mem_q;
  logic                w_wr, w_rd, w_pop, w_tlast;
  logic [2:0]          w_occ_after;
  logic [CNT_BITS-1:0] w_last_idx;

  memory_2p #(.WIDTH(OUTW), .SIZE(DEPTH)) u_mem (
    .clk     (clk),
    .wr_en   (w_wr),
    .wr_addr (r_wr_ptr),
    .data_in (in_data),
    .rd_addr (r_rd_ptr),
    .data_out(w_mem_q)
  );

  assign w_wr  = in_valid && r_in_ready;
  assign w_pop = (r_sk_cnt != 2'd0) && AXIS_TREADY;

  // Skid occupancy plus in-flight read after this cycle's pop; keeps it at most 2.
  assign w_occ_after = {1'b0, r_sk_cnt} + {2'b00, r_rd_pend} - {2'b00, w_pop};
  assign w_rd        = (r_count != '0) && (w_occ_after < 3'd2);

  assign w_last_idx = CNT_BITS'(out_matrix_last(R, C, int'(K)));
  assign w_tlast    = (r_sk_cnt != 2'd0) && (r_out_cnt == w_last_idx);

  always_comb begin
    w_count_nxt = r_count;
    if (w_wr && !w_rd)      w_count_nxt = r_count + FW'(1);
    else if (!w_wr && w_rd) w_count_nxt = r_count - FW'(1);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_wr_ptr      <= '0;
      r_rd_ptr      <= '0;
      r_count       <= '0;
      r_in_ready    <= 1'b0;
      r_rd_pend     <= 1'b0;
      r_sk_cnt      <= 2'd0;
      r_out_cnt     <= '0;
      r_matrix_sent <= 1'b0;
    end else begin
      if (w_wr) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_rd) r_rd_ptr <= r_rd_ptr + AW'(1);
      r_count       <= w_count_nxt;
      r_in_ready    <= (w_count_nxt < C_DEPTH);
      r_rd_pend     <= w_rd;
      r_sk_cnt      <= w_occ_after[1:0];
      r_matrix_sent <= w_pop && w_tlast;
      if (w_pop) r_out_cnt <= w_tlast ? '0 : r_out_cnt + CNT_BITS'(1);
    end
  end

  // Skid payload; entry 0 is always the word presented on AXIS.
  always_ff @(posedge clk) begin
    case ({r_rd_pend, w_pop})
      2'b10: begin
        if (r_sk_cnt == 2'd0) r_sk0 <= w_mem_q;
        else                  r_sk1 <= w_mem_q;
      end
      2'b01: r_sk0 <= r_sk1;
      2'b11: begin
        if (r_sk_cnt == 2'd1) begin
          r_sk0 <= w_mem_q;
        end else begin
          r_sk0 <= r_sk1;
          r_sk1 <= w_mem_q;
        end
      end
      default: ;
    endcase
  end

  assign in_ready    = r_in_ready;
  assign AXIS_TDATA  = r_sk0;
  assign AXIS_TVALID = (r_sk_cnt != 2'd0);
  assign AXIS_TLAST  = w_tlast;
  assign matrix_sent = r_matrix_sent;

endmodule
`default_nettype wire

// File: tb/tb_output_stream_tx.sv
`default_nettype none
// ============================================================================
// tb_output_stream_tx : directed self-checking bench for output_stream_tx
// Revision: 1.0
// ============================================================================
module tb_output_stream_tx;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [47:0] in_data = '0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [2:0]  K = 3'd1;
  logic [47:0] tdata;
  logic        tvalid;
  logic        tready = 1'b0;
  logic        tlast;
  logic        matrix_sent;

  always #5 clk = ~clk;

  output_stream_tx dut (
    .clk        (clk),
    .reset      (reset),
    .in_data    (in_data),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .K          (K),
    .AXIS_TDATA (tdata),
    .AXIS_TVALID(tvalid),
    .AXIS_TREADY(tready),
    .AXIS_TLAST (tlast),
    .matrix_sent(matrix_sent)
  );

  int          checks = 0;
  int          errors = 0;
  logic [47:0] exp_q[$];
  logic [47:0] next_word;
  logic [47:0] prev_data;
  logic [2:0]  k_tab[4];
  int          last_tab[4];
  int          src_left, got, n_target, out_idx, mat, nmat, pulses;
  int          cyc_no, first_in, first_v, bubbles, acc;
  bit          k_pend, prev_stall, prev_last, prev_tl;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  task automatic clear_model();
    exp_q.delete();
    out_idx = 0; mat = 0; nmat = 0; pulses = 0; got = 0;
    k_pend = 0; prev_stall = 0; prev_tl = 0;
  endtask

  task automatic do_reset(input logic [2:0] k0, input int last0, input logic [2:0] k1, input int last1);
    reset = 1'b1; in_valid = 1'b0; tready = 1'b0; in_data = '0;
    k_tab = '{k0, k1, k1, k1};
    last_tab = '{last0, last1, last1, last1};
    K = k0;
    clear_model();
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_tvalid", 64'(tvalid), 64'(0));
    chk("rst_in_ready", 64'(in_ready), 64'(0));
    reset = 1'b0;
    @(negedge clk);
    chk("post_rst_in_ready", 64'(in_ready), 64'(1));
    chk("post_rst_tvalid", 64'(tvalid), 64'(0));
    chk("post_rst_msent", 64'(matrix_sent), 64'(0));
  endtask

  task automatic cyc(input int vp, input int rp);
    logic in_hs, out_hs;
    @(negedge clk);
    if (k_pend) begin
      K = k_tab[mat];
      k_pend = 0;
      #1;
    end
    cyc_no++;
    chk("matrix_sent", 64'(matrix_sent), 64'(prev_tl));
    if (matrix_sent) pulses++;
    if (prev_stall) begin
      chk("hold_tvalid", 64'(tvalid), 64'(1));
      chk("hold_tdata", 64'(tdata), 64'(prev_data));
      chk("hold_tlast", 64'(tlast), 64'(prev_last));
    end
    if (tvalid && first_v < 0) first_v = cyc_no;
    if (got > 0 && got < n_target && !tvalid) bubbles++;
    in_valid = (src_left > 0) && (int'($urandom_range(0, 99)) < vp);
    in_data  = next_word;
    tready   = (int'($urandom_range(0, 99)) < rp);
    in_hs  = in_valid && in_ready;
    out_hs = tvalid && tready;
    if (in_hs) begin
      if (first_in < 0) first_in = cyc_no;
      exp_q.push_back(in_data);
      next_word++;
      src_left--;
    end
    if (out_hs) begin
      if (exp_q.size() == 0) chk("spurious_word", 64'(tvalid), 64'(0));
      else                   chk("tdata", 64'(tdata), 64'(exp_q.pop_front()));
      chk("tlast", 64'(tlast), 64'(out_idx == last_tab[mat]));
      if (out_idx == last_tab[mat]) begin
        out_idx = 0;
        nmat++;
        if (mat < 3) mat++;
        k_pend = 1;
      end else begin
        out_idx++;
      end
      got++;
    end
    prev_stall = tvalid && !tready;
    prev_data  = tdata;
    prev_last  = tlast;
    prev_tl    = out_hs && tlast;
  endtask

  task automatic run_stream(input int n_in, input logic [47:0] base, input int n_out,
                            input int vp, input int rp, input int budget);
    src_left = n_in; next_word = base; n_target = n_out; got = 0;
    first_in = -1; first_v = -1; bubbles = 0; cyc_no = 0;
    for (int i = 0; i < budget && got < n_out; i++) cyc(vp, rp);
    chk("words_out", 64'(got), 64'(n_out));
    repeat (3) cyc(0, 100);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog_timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    // 1: continuous stream, K=2 -> 8x7 = 56 words, TLAST on index 55
    do_reset(3'd2, 55, 3'd2, 55);
    run_stream(56, 48'd0, 56, 100, 100, 400);
    chk("t1_latency", 64'(first_v - first_in), 64'(3));
    chk("t1_bubbles", 64'(bubbles), 64'(0));
    chk("t1_matrices", 64'(nmat), 64'(1));
    chk("t1_pulses", 64'(pulses), 64'(1));

    // 2: backpressure, DEPTH + 2 skid entries = 10 accepted
    do_reset(3'd2, 55, 3'd2, 55);
    acc = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (!in_ready) break;
      in_valid = 1'b1;
      in_data  = 48'd200 + 48'(acc);
      exp_q.push_back(in_data);
      acc++;
    end
    in_valid = 1'b0;
    chk("t2_accepted", 64'(acc), 64'(10));
    repeat (3) @(negedge clk);
    chk("t2_in_ready_low", 64'(in_ready), 64'(0));
    chk("t2_tvalid", 64'(tvalid), 64'(1));
    chk("t2_head", 64'(tdata), 64'(200));
    prev_stall = 0; prev_tl = 0;
    run_stream(0, 48'd0, 10, 0, 100, 100);
    chk("t2_in_ready_back", 64'(in_ready), 64'(1));

    // 3: random stalls, K=4 -> 6x5 = 30 words, TLAST on index 29
    do_reset(3'd4, 29, 3'd4, 29);
    run_stream(30, 48'd300, 30, 50, 50, 3000);
    chk("t3_matrices", 64'(nmat), 64'(1));

    // 4: reset mid-stream with 5 words buffered and 7 already framed
    do_reset(3'd4, 29, 3'd4, 29);
    run_stream(7, 48'd400, 7, 100, 100, 100);
    tready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      in_valid = 1'b1;
      in_data  = 48'd500 + 48'(i);
    end
    @(negedge clk);
    in_valid = 1'b0;
    repeat (3) @(negedge clk);
    chk("t4_pre_tvalid", 64'(tvalid), 64'(1));
    @(posedge clk);
    #2 reset = 1'b1;
    #1;
    chk("t4_async_tvalid", 64'(tvalid), 64'(0));
    chk("t4_async_tlast", 64'(tlast), 64'(0));
    chk("t4_async_in_ready", 64'(in_ready), 64'(0));
    chk("t4_async_msent", 64'(matrix_sent), 64'(0));
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    clear_model();
    run_stream(30, 48'd100, 30, 100, 100, 300);
    chk("t4_matrices", 64'(nmat), 64'(1));

    // 5: back-to-back K=3 (7x6=42) then K=1 (9x8=72), TLAST on 41 and 113
    do_reset(3'd3, 41, 3'd1, 71);
    run_stream(114, 48'd1000, 114, 100, 100, 600);
    chk("t5_bubbles", 64'(bubbles), 64'(0));
    chk("t5_matrices", 64'(nmat), 64'(2));
    chk("t5_pulses", 64'(pulses), 64'(2));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
